// File: rtl/mem_data_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_data_ctrl_pkg
//  Description : Shared widths, operation IDs, FSM encodings, MSB entry type
//                and byte-count / load-extension helpers for mem_data_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_data_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int OP_W   = 6;

    // Load/store operation IDs carried on the OP_ID buses
    localparam logic [OP_W-1:0] c_op_lb  = 6'd1;
    localparam logic [OP_W-1:0] c_op_lh  = 6'd2;
    localparam logic [OP_W-1:0] c_op_lw  = 6'd3;
    localparam logic [OP_W-1:0] c_op_lbu = 6'd4;
    localparam logic [OP_W-1:0] c_op_lhu = 6'd5;
    localparam logic [OP_W-1:0] c_op_sb  = 6'd6;
    localparam logic [OP_W-1:0] c_op_sh  = 6'd7;
    localparam logic [OP_W-1:0] c_op_sw  = 6'd8;

    // Controller FSM encodings
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_load   = 2'd1;
    localparam logic [1:0] c_st_finish = 2'd2;
    localparam logic [1:0] c_st_store  = 2'd3;

    localparam int c_entry_w = OP_W + ADDR_W + DATA_W;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] value;
    } msb_entry_t;

    // Number of bytes moved by an access (1, 2 or 4)
    function automatic logic [2:0] op_nbytes(input logic [OP_W-1:0] op);
        case (op)
            c_op_lb, c_op_lbu, c_op_sb: return 3'd1;
            c_op_lh, c_op_lhu, c_op_sh: return 3'd2;
            default:                    return 3'd4;
        endcase
    endfunction

    // Sign/zero extension of the little-endian assembled load bytes
    function automatic logic [DATA_W-1:0] load_extend(input logic [OP_W-1:0]   op,
                                                      input logic [DATA_W-1:0] raw);
        case (op)
            c_op_lb:  return {{24{raw[7]}}, raw[7:0]};
            c_op_lbu: return {24'b0, raw[7:0]};
            c_op_lh:  return {{16{raw[15]}}, raw[15:0]};
            c_op_lhu: return {16'b0, raw[15:0]};
            default:  return raw;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_data_ctrl_msb_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : msb_fifo
//  Description : Memory store buffer - circular FIFO of committed stores
//                {OP_ID, addr, value}. Pushes into a full buffer are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module msb_fifo
    import mem_data_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     push,
    input  logic [c_entry_w-1:0]     push_data,
    input  logic                     pop,
    output logic [c_entry_w-1:0]     head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [c_entry_w-1:0] mem_q [DEPTH];
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w:0]     count_q, count_d;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == c_depth);

    // Pointer and occupancy update; simultaneous push and pop leave count unchanged
    always_comb begin
        w_do_push = en && push && !full;
        w_do_pop  = en && pop && (count_q != '0);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + (c_ptr_w + 1)'(1);
            2'b01:   count_d = count_q - (c_ptr_w + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/mem_data_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_data_ctrl
//  Description : Data-side memory controller. Serves byte-serial loads with
//                sign/zero extension and drains ROB-committed stores from the
//                store buffer onto the byte-wide RAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_data_ctrl
    import mem_data_ctrl_pkg::*;
#(
    parameter int MSB_DEPTH   = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        LS_need_load,
    input  logic [5:0]  LS_OP_ID,
    input  logic [31:0] LS_load_addr,
    output logic        LS_finish_load,
    output logic [31:0] LS_value,
    output logic        LS_MSB_is_full,
    input  logic        ROB_commit_store,
    input  logic [5:0]  ROB_store_OP_ID,
    input  logic [31:0] ROB_store_addr,
    input  logic [31:0] ROB_store_value,
    input  logic        ROB_roll_back_flag,
    input  logic        mem_grant,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic        mem_req,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr
);

    localparam int                 c_cnt_w      = $clog2(MSB_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full_level = c_cnt_w'(MSB_DEPTH - FULL_MARGIN);

    logic [1:0]           state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 cap_q, cap_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [5:0]           pend_op_q, pend_op_d;
    logic [31:0]          pend_addr_q, pend_addr_d;
    logic [5:0]           ld_op_q, ld_op_d;
    logic [31:0]          ld_addr_q, ld_addr_d;
    logic [31:0]          ld_data_q, ld_data_d;
    logic                 full_q, full_d;

    logic [c_entry_w-1:0] w_head_bits;
    msb_entry_t           w_head;
    logic [c_cnt_w-1:0]   w_msb_count;
    logic                 w_msb_full;
    logic                 w_msb_empty;
    logic                 w_pop;
    logic                 w_start_load;
    logic                 w_io_stall;
    logic [2:0]           w_ld_n;
    logic [2:0]           w_st_n;
    logic [1:0]           w_cap_idx;

    msb_fifo #(
        .DEPTH (MSB_DEPTH)
    ) u_msb (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .push      (ROB_commit_store && !w_msb_full),
        .push_data ({ROB_store_OP_ID, ROB_store_addr, ROB_store_value}),
        .pop       (w_pop),
        .head      (w_head_bits),
        .count     (w_msb_count),
        .full      (w_msb_full)
    );

    assign w_head      = msb_entry_t'(w_head_bits);
    assign w_msb_empty = (w_msb_count == '0);
    assign w_ld_n      = op_nbytes(ld_op_q);
    assign w_st_n      = op_nbytes(w_head.op);
    // Byte landing on mem_din this cycle was issued with the previous count
    assign w_cap_idx   = cnt_q[1:0] - 2'd1;
    // IO sink busy only blocks a store before its first byte goes out
    assign w_io_stall  = (cnt_q == 3'd0) && (w_head.addr[17:16] == 2'b11) && io_buffer_full;
    assign LS_MSB_is_full = full_q;

    // FSM state and byte-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_st_idle;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    // Next-state: stores drain before any load starts; rollback only aborts loads
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_d        = 1'b0;
        w_pop        = 1'b0;
        w_start_load = 1'b0;
        case (state_q)
            c_st_idle: begin
                cnt_d = '0;
                if (!w_msb_empty) begin
                    state_d = c_st_store;
                end else if (pend_vld_q && !ROB_roll_back_flag) begin
                    state_d      = c_st_load;
                    w_start_load = 1'b1;
                end
            end
            c_st_load: begin
                if (ROB_roll_back_flag) begin
                    state_d = c_st_idle;
                    cnt_d   = '0;
                end else begin
                    if ((cnt_q != w_ld_n) && mem_grant) begin
                        cnt_d = cnt_q + 3'd1;
                        cap_d = 1'b1;
                    end
                    if (cap_q && (cnt_q == w_ld_n)) begin
                        state_d = c_st_finish;
                    end
                end
            end
            c_st_finish: begin
                state_d = c_st_idle;
                cnt_d   = '0;
            end
            c_st_store: begin
                if (!w_io_stall && mem_grant) begin
                    if (cnt_q == (w_st_n - 3'd1)) begin
                        cnt_d   = '0;
                        w_pop   = 1'b1;
                        state_d = c_st_idle;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // Outputs decoded from the current state and byte counter
    always_comb begin
        mem_req        = 1'b0;
        mem_wr         = 1'b0;
        mem_a          = '0;
        mem_dout       = '0;
        LS_finish_load = 1'b0;
        LS_value       = '0;
        case (state_q)
            c_st_load: begin
                mem_req = !ROB_roll_back_flag;
                mem_a   = ld_addr_q + {29'b0, cnt_q};
            end
            c_st_finish: begin
                LS_finish_load = !ROB_roll_back_flag;
                if (!ROB_roll_back_flag) LS_value = load_extend(ld_op_q, ld_data_q);
            end
            c_st_store: begin
                mem_req  = !w_io_stall;
                mem_wr   = !w_io_stall;
                mem_a    = w_head.addr + {29'b0, cnt_q};
                mem_dout = w_head.value[{cnt_q[1:0], 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    // Pending-load capture, active-load copy, byte assembly and full flag
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_op_d   = pend_op_q;
        pend_addr_d = pend_addr_q;
        ld_op_d     = ld_op_q;
        ld_addr_d   = ld_addr_q;
        ld_data_d   = ld_data_q;
        full_d      = (w_msb_count >= c_full_level);
        if (w_start_load) begin
            pend_vld_d = 1'b0;
            ld_op_d    = pend_op_q;
            ld_addr_d  = pend_addr_q;
            ld_data_d  = '0;
        end
        if (ROB_roll_back_flag) begin
            pend_vld_d = 1'b0;
        end else if (LS_need_load) begin
            pend_vld_d  = 1'b1;
            pend_op_d   = LS_OP_ID;
            pend_addr_d = LS_load_addr;
        end
        if ((state_q == c_st_load) && cap_q && !ROB_roll_back_flag) begin
            ld_data_d[{w_cap_idx, 3'b000} +: 8] = mem_din;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q  <= 1'b0;
            pend_op_q   <= '0;
            pend_addr_q <= '0;
            ld_op_q     <= '0;
            ld_addr_q   <= '0;
            ld_data_q   <= '0;
            full_q      <= 1'b0;
        end else if (rdy) begin
            pend_vld_q  <= pend_vld_d;
            pend_op_q   <= pend_op_d;
            pend_addr_q <= pend_addr_d;
            ld_op_q     <= ld_op_d;
            ld_addr_q   <= ld_addr_d;
            ld_data_q   <= ld_data_d;
            full_q      <= full_d;
        end
    end

endmodule
`default_nettype wire
